lane_deserializer: RTL and testbench
====================================

# lane_deserializer

Per-lane receive deserializer for the two-lane PHY datapath. Takes one serial bit per clock, finds byte alignment by hunting for the COM symbol, declares the lane active after a run of consecutive COMs, then packs the data bytes that follow into 32-bit words. One instance per lane feeds the byte unstriping stage: `lane_out`/`valid_out` drive its `lane_N`/`valid_N` inputs.

## Interface
- `COM`, default 8'hBC: alignment/filler symbol.
- `LOCK_COUNT`, default 4: consecutive aligned COMs needed for lock; range 1..15.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `serial_in` input 1: serial data, one bit per `clk`, MSB of each byte first.
- `active` output 1: lane locked; registered.
- `valid_out` output 1: one-cycle pulse, `lane_out` holds a new word; registered.
- `lane_out` output 32: assembled word; first received byte in [31:24], last in [7:0]; registered.

## Operation
- Reset values: `active`=0, `valid_out`=0, `lane_out`=0. Internal shift register, bit counter, COM counter, byte counter and state all clear to 0 / HUNT.
- Candidate byte at each edge = {shift[6:0], serial_in}, the byte completed by the current bit. The shift register always shifts in `serial_in`.
- States:
  - HUNT: at each edge, if candidate == COM, go to SYNC with com_count=1 and bit_cnt=0; otherwise stay. Alignment is bit-granular: any bit offset is accepted.
  - SYNC: bit_cnt counts 0..7. At the edge with bit_cnt==7, check the candidate:
    - If it equals COM, com_count++; when com_count reaches LOCK_COUNT, go to LOCKED and set `active`=1 at that edge.
    - If it is anything else, go to HUNT and clear com_count.
    - LOCK_COUNT=1 locks on the first COM found in HUNT.
  - LOCKED: bit_cnt keeps running mod 8. At each byte boundary:
    - A COM byte is filler: discarded, with no effect on word assembly.
    - Any other byte is stored at position byte_cnt (0→[31:24] … 3→[7:0]), and byte_cnt increments.
    - On the 4th stored byte, `lane_out` takes the complete word and `valid_out`=1 for one cycle. byte_cnt wraps to 0.
- LOCKED is left only by `reset`. Lock is not dropped on data errors.
- Between words, `lane_out` holds its last value and `valid_out`=0.
- A partially assembled word is never emitted. The partial bytes are discarded only by `reset`.

## Timing
- Example: COMs aligned from cycle 0, LOCK_COUNT=4. The last bit of the 4th COM is sampled at edge 31, so `active` is high from cycle 32.
- Word latency: the last bit of the 4th data byte is sampled at edge N; `valid_out`=1 and `lane_out` is valid during cycle N+1 only.
- Back-to-back data gives one `valid_out` pulse every 32 cycles. Each interleaved COM adds 8 cycles.
- `reset` asserted mid-word or mid-sync drops `active`/`valid_out` and zeroes `lane_out` without waiting for a clock edge. After release, hunting restarts from an empty shift register: old bits never contribute to a candidate.
- `valid_out` is never asserted while `active`=0.

## Test plan
- Reset check: assert `reset` with random `serial_in`; `active`=0, `valid_out`=0, `lane_out`=0 with no clock edge required. All three stay 0 for 100 cycles of 0x00 bytes.
- Lock and first word: 4×0xBC then 0xDE,0xAD,0xBE,0xEF from cycle 0.
  - `active` rises at cycle 32.
  - `valid_out` pulses in cycle 64 only, with `lane_out`=32'hDEADBEEF.
- Misaligned start: 3 arbitrary bits, then the same stream. `active` rises at cycle 35; word 32'hDEADBEEF is emitted at cycle 67.
- Broken sync: 0xBC,0xBC,0xBC,0x00, then 4×0xBC, then 0x12345678.
  - `active` stays 0 through the 0x00 byte and rises only after the second COM run (cycle 64).
  - `lane_out`=32'h12345678 is emitted at cycle 96.
- Filler skip: after lock, send 0x11,0xBC,0x22,0x33,0xBC,0x44. Exactly one `valid_out` pulse, at cycle after the 0x44 byte (48 bits after data start), with `lane_out`=32'h11223344.
- Reset mid-word: after lock, send 2 data bytes, pulse `reset` asynchronously, then send 4×0xBC + 0xCAFEF00D. The only word emitted is 32'hCAFEF00D, 32 cycles after `active` re-asserts.

Source files
------------

// File: rtl/lane_deserializer.sv
// lane_deserializer: per-lane receive deserializer.
// Hunts for the COM symbol at any bit offset, confirms alignment with a run
// of consecutive COMs, then packs the non-COM bytes that follow into 32-bit
// words (first byte in [31:24]). Once locked, only reset leaves LOCKED.
module lane_deserializer #(
    parameter logic [7:0] COM        = 8'hBC,
    parameter int         LOCK_COUNT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        serial_in,
    output logic        active,
    output logic        valid_out,
    output logic [31:0] lane_out
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

    state_t      state;
    state_t      state_next;

    logic [7:0]  shift_reg;
    logic [2:0]  bit_cnt;
    logic [3:0]  com_count;
    logic [1:0]  byte_cnt;
    logic [23:0] word_buf;

    logic [7:0]  candidate;
    logic        is_com;
    logic        at_boundary;
    logic [3:0]  com_count_inc;
    logic        store_byte;
    logic        word_done;
    logic        active_next;

    // Byte completed by the current bit, and where we are within a byte.
    assign candidate     = {shift_reg[6:0], serial_in};
    assign is_com        = (candidate == COM);
    assign at_boundary   = (bit_cnt == 3'd7);
    assign com_count_inc = com_count + 4'd1;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: hunt for COM, confirm the COM run, then stay locked.
    always_comb begin
        state_next = state;
        case (state)
            HUNT: begin
                if (is_com) begin
                    state_next = (LOCK_TARGET == 4'd1) ? LOCKED : SYNC;
                end
            end
            SYNC: begin
                if (at_boundary) begin
                    if (!is_com) begin
                        state_next = HUNT;
                    end else if (com_count_inc == LOCK_TARGET) begin
                        state_next = LOCKED;
                    end
                end
            end
            LOCKED: begin
                state_next = LOCKED;
            end
            default: begin
                state_next = HUNT;
            end
        endcase
    end

    // Output decode: which byte boundaries store data and which finish a word.
    always_comb begin
        store_byte  = 1'b0;
        word_done   = 1'b0;
        active_next = (state_next == LOCKED);
        if (state == LOCKED && at_boundary && !is_com) begin
            store_byte = 1'b1;
            word_done  = (byte_cnt == 2'd3);
        end
    end

    // Alignment bookkeeping: shift register, bit counter and COM run counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= 8'd0;
            bit_cnt   <= 3'd0;
            com_count <= 4'd0;
        end else begin
            shift_reg <= candidate;
            case (state)
                HUNT: begin
                    bit_cnt   <= 3'd0;
                    com_count <= is_com ? 4'd1 : 4'd0;
                end
                SYNC: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (at_boundary) begin
                        com_count <= is_com ? com_count_inc : 4'd0;
                    end
                end
                default: begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            endcase
        end
    end

    // Word assembly: the first three bytes wait in word_buf, the fourth completes the word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt  <= 2'd0;
            word_buf  <= 24'd0;
            lane_out  <= 32'd0;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            active    <= active_next;
            valid_out <= word_done;
            if (store_byte) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0:    word_buf[23:16] <= candidate;
                    2'd1:    word_buf[15:8]  <= candidate;
                    2'd2:    word_buf[7:0]   <= candidate;
                    default: lane_out        <= {word_buf, candidate};
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lane_deserializer.sv
// tb_lane_deserializer: directed scenarios plus randomized streams, every
// cycle compared against a byte-level reference model of the lane rules.
module tb_lane_deserializer;

    localparam logic [7:0] COM = 8'hBC;
    localparam int         LC  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        serial_in = 1'b0;
    logic        active;
    logic        valid_out;
    logic [31:0] lane_out;

    int error_count = 0;
    int check_count = 0;

    // Reference model state: edges since reset, alignment anchor, COM run, stored bytes.
    logic [7:0]  m_hist;
    int          m_edges;
    int          m_mode;
    int          m_anchor;
    int          m_run;
    logic [7:0]  m_bytes[$];
    logic        m_active;
    logic        m_valid;
    logic [31:0] m_word;

    // Observations used by the directed scenarios.
    int          rise_cycle;
    int          valid_cycle;
    int          valid_count;
    logic [31:0] last_word;
    logic        prev_active;

    lane_deserializer #(.COM(COM), .LOCK_COUNT(LC)) dut (
        .clk       (clk),
        .reset     (reset),
        .serial_in (serial_in),
        .active    (active),
        .valid_out (valid_out),
        .lane_out  (lane_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_hist   = 8'd0;
        m_edges  = 0;
        m_mode   = 0;
        m_anchor = 0;
        m_run    = 0;
        m_bytes.delete();
        m_active = 1'b0;
        m_valid  = 1'b0;
        m_word   = 32'd0;
        rise_cycle  = -1;
        valid_cycle = -1;
        valid_count = 0;
        last_word   = 32'd0;
        prev_active = 1'b0;
    endtask

    // One edge of the lane rules: byte boundaries fall every 8 edges after the anchor COM.
    task automatic model_step(input logic b);
        logic [7:0] cand;
        logic       boundary;
        cand     = {m_hist[6:0], b};
        m_hist   = cand;
        m_valid  = 1'b0;
        boundary = (m_mode != 0) && (((m_edges - m_anchor) % 8) == 0);
        if (m_mode == 0) begin
            if (cand == COM) begin
                m_anchor = m_edges;
                m_run    = 1;
                m_mode   = (LC == 1) ? 2 : 1;
            end
        end else if (m_mode == 1) begin
            if (boundary) begin
                if (cand == COM) begin
                    m_run++;
                    if (m_run == LC) m_mode = 2;
                end else begin
                    m_mode = 0;
                    m_run  = 0;
                end
            end
        end else begin
            if (boundary && cand != COM) begin
                m_bytes.push_back(cand);
                if (m_bytes.size() == 4) begin
                    m_word  = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                    m_valid = 1'b1;
                    m_bytes.delete();
                end
            end
        end
        m_active = (m_mode == 2);
        m_edges++;
    endtask

    // Drive one bit, let the edge happen, then compare the cycle that follows.
    task automatic send_bit(input logic b);
        serial_in = b;
        @(posedge clk);
        #1;
        model_step(b);
        checkOutput("active", {31'd0, active}, {31'd0, m_active});
        checkOutput("valid_out", {31'd0, valid_out}, {31'd0, m_valid});
        checkOutput("lane_out", lane_out, m_word);
        if (active && !prev_active) rise_cycle = m_edges;
        prev_active = active;
        if (valid_out) begin
            valid_count++;
            valid_cycle = m_edges;
            last_word   = lane_out;
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] byte_val);
        for (int i = 7; i >= 0; i--) send_bit(byte_val[i]);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) applyStimulus(w[i*8 +: 8]);
    endtask

    task automatic send_coms(input int n);
        for (int i = 0; i < n; i++) applyStimulus(COM);
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock edge.
    task automatic reset_dut();
        #2;
        serial_in = 1'($urandom);
        reset = 1'b1;
        #1;
        checkOutput("rst_active", {31'd0, active}, 32'd0);
        checkOutput("rst_valid", {31'd0, valid_out}, 32'd0);
        checkOutput("rst_lane_out", lane_out, 32'd0);
        repeat (2) begin
            @(negedge clk);
            serial_in = 1'($urandom);
        end
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        // Reset, then a long run of zero bytes must never lock.
        reset_dut();
        for (int i = 0; i < 13; i++) applyStimulus(8'h00);
        checkOutput("zeros_valid_count", 32'(valid_count), 32'd0);
        checkOutput("zeros_rise", 32'(rise_cycle), 32'hFFFF_FFFF);

        // Aligned lock and first word.
        reset_dut();
        send_coms(4);
        send_word(32'hDEADBEEF);
        checkOutput("lock_rise_cycle", 32'(rise_cycle), 32'd32);
        checkOutput("first_valid_cycle", 32'(valid_cycle), 32'd64);
        checkOutput("first_word", last_word, 32'hDEADBEEF);
        checkOutput("first_valid_count", 32'(valid_count), 32'd1);

        // Misaligned start by three arbitrary bits.
        reset_dut();
        for (int i = 0; i < 3; i++) send_bit(1'($urandom));
        send_coms(4);
        send_word(32'hDEADBEEF);
        checkOutput("mis_rise_cycle", 32'(rise_cycle), 32'd35);
        checkOutput("mis_valid_cycle", 32'(valid_cycle), 32'd67);
        checkOutput("mis_word", last_word, 32'hDEADBEEF);

        // Broken COM run restarts the hunt.
        reset_dut();
        send_coms(3);
        applyStimulus(8'h00);
        send_coms(4);
        send_word(32'h12345678);
        checkOutput("broken_rise_cycle", 32'(rise_cycle), 32'd64);
        checkOutput("broken_valid_cycle", 32'(valid_cycle), 32'd96);
        checkOutput("broken_word", last_word, 32'h12345678);

        // Filler COMs after lock are skipped.
        reset_dut();
        send_coms(4);
        applyStimulus(8'h11);
        applyStimulus(COM);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        applyStimulus(COM);
        applyStimulus(8'h44);
        checkOutput("filler_valid_count", 32'(valid_count), 32'd1);
        checkOutput("filler_valid_cycle", 32'(valid_cycle), 32'd80);
        checkOutput("filler_word", last_word, 32'h11223344);

        // Reset mid-word discards the partial bytes.
        reset_dut();
        send_coms(4);
        applyStimulus(8'hA5);
        applyStimulus(8'h5A);
        reset_dut();
        send_coms(4);
        send_word(32'hCAFEF00D);
        checkOutput("midrst_valid_count", 32'(valid_count), 32'd1);
        checkOutput("midrst_word", last_word, 32'hCAFEF00D);
        checkOutput("midrst_latency", 32'(valid_cycle - rise_cycle), 32'd32);

        // Randomized streams: random offset, COM run, data with sprinkled filler.
        for (int round = 0; round < 12; round++) begin
            int offset;
            reset_dut();
            offset = int'($urandom_range(0, 7));
            for (int i = 0; i < offset; i++) send_bit(1'($urandom));
            if (round % 4 == 3) begin
                for (int i = 0; i < 30; i++) applyStimulus(8'($urandom));
            end else begin
                send_coms((round % 4 == 2) ? 3 : 4);
                for (int i = 0; i < 30; i++) begin
                    if ($urandom_range(0, 3) == 0) applyStimulus(COM);
                    else applyStimulus(8'($urandom));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
